// File: rtl/ps2_zx_keyboard.sv
// PS/2 set-2 keyboard front end for a ZX Spectrum core: builds the 8x5 key
// matrix answered on ULA port #FE reads and drives the system hotkey levels.
module ps2_zx_keyboard #(
  parameter int TIMEOUT = 56000,
  parameter int CNT_W   = 16
) (
  input  logic       clk_sys,
  input  logic       nRESET,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] addr_hi,
  output logic [4:0] key_data,
  output logic       F1,
  output logic       F11,
  output logic       warm_reset,
  output logic       cold_reset,
  output logic       test_reset
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_REL, S_EXT_REL} dec_state_e;

  // ------------------------------------------------------------------
  // Input synchronisers and falling-edge detect
  // ------------------------------------------------------------------
  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;
  logic       ps2_fall;
  logic       ps2_bit;

  // Idle PS/2 lines sit high, so the sync chain resets high to avoid a fake edge.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign ps2_fall = clk_prev_q & ~clk_sync_q[1];
  assign ps2_bit  = data_sync_q[1];

  // ------------------------------------------------------------------
  // Frame receiver
  // ------------------------------------------------------------------
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tmo_d        = tmo_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (ps2_fall) begin
      tmo_d = '0;
      if (bit_cnt_q == 4'd0) begin
        if (!ps2_bit) begin
          bit_cnt_d = 4'd1;
        end
      end else if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        // shift_q holds parity in [8] and data in [7:0]; odd parity overall
        if ((^shift_q) && ps2_bit) begin
          byte_valid_d = 1'b1;
          rx_byte_d    = shift_q[7:0];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d   = {ps2_bit, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_q == TMO_LAST) begin
        bit_cnt_d   = 4'd0;
        tmo_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      tmo_q        <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tmo_q        <= tmo_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ------------------------------------------------------------------
  // Scancode to matrix mask; bit index is row*5 + column
  // ------------------------------------------------------------------
  function automatic logic [39:0] key_mask(input logic ext, input logic [7:0] code);
    logic [39:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        8'h12: m[0]  = 1'b1;  8'h1A: m[1]  = 1'b1;  8'h22: m[2]  = 1'b1;
        8'h21: m[3]  = 1'b1;  8'h2A: m[4]  = 1'b1;
        8'h1C: m[5]  = 1'b1;  8'h1B: m[6]  = 1'b1;  8'h23: m[7]  = 1'b1;
        8'h2B: m[8]  = 1'b1;  8'h34: m[9]  = 1'b1;
        8'h15: m[10] = 1'b1;  8'h1D: m[11] = 1'b1;  8'h24: m[12] = 1'b1;
        8'h2D: m[13] = 1'b1;  8'h2C: m[14] = 1'b1;
        8'h16: m[15] = 1'b1;  8'h1E: m[16] = 1'b1;  8'h26: m[17] = 1'b1;
        8'h25: m[18] = 1'b1;  8'h2E: m[19] = 1'b1;
        8'h45: m[20] = 1'b1;  8'h46: m[21] = 1'b1;  8'h3E: m[22] = 1'b1;
        8'h3D: m[23] = 1'b1;  8'h36: m[24] = 1'b1;
        8'h4D: m[25] = 1'b1;  8'h44: m[26] = 1'b1;  8'h43: m[27] = 1'b1;
        8'h3C: m[28] = 1'b1;  8'h35: m[29] = 1'b1;
        8'h5A: m[30] = 1'b1;  8'h4B: m[31] = 1'b1;  8'h42: m[32] = 1'b1;
        8'h3B: m[33] = 1'b1;  8'h33: m[34] = 1'b1;
        8'h29: m[35] = 1'b1;  8'h59: m[36] = 1'b1;  8'h14: m[36] = 1'b1;
        8'h3A: m[37] = 1'b1;  8'h31: m[38] = 1'b1;  8'h32: m[39] = 1'b1;
        8'h66: begin m[0] = 1'b1; m[20] = 1'b1; end
        default: m = '0;
      endcase
    end else begin
      // Cursor keys are CAPS SHIFT plus 5/6/7/8
      case (code)
        8'h5A: m[30] = 1'b1;
        8'h14: m[36] = 1'b1;
        8'h6B: begin m[0] = 1'b1; m[19] = 1'b1; end
        8'h72: begin m[0] = 1'b1; m[24] = 1'b1; end
        8'h75: begin m[0] = 1'b1; m[23] = 1'b1; end
        8'h74: begin m[0] = 1'b1; m[22] = 1'b1; end
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  // ------------------------------------------------------------------
  // Decoder FSM, matrix, modifiers and hotkeys
  // ------------------------------------------------------------------
  dec_state_e  state_q;
  logic [39:0] matrix_q;
  logic [3:0]  mod_q;  // {right alt, left alt, right ctrl, left ctrl}
  logic        f1_q, f11_q, warm_q, cold_q, test_q;
  logic        dec_ext, dec_brk;
  logic [8:0]  dec_code;
  logic [39:0] dec_mask;

  always_comb begin
    dec_ext  = (state_q == S_EXT) || (state_q == S_EXT_REL);
    dec_brk  = (state_q == S_REL) || (state_q == S_EXT_REL);
    dec_code = {dec_ext, rx_byte_q};
    dec_mask = key_mask(dec_ext, rx_byte_q);
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= S_IDLE;
      matrix_q <= '0;
      mod_q    <= '0;
      f1_q     <= 1'b0;
      f11_q    <= 1'b0;
      warm_q   <= 1'b0;
      cold_q   <= 1'b0;
      test_q   <= 1'b0;
    end else if (frame_err_q) begin
      state_q <= S_IDLE;
    end else if (byte_valid_q) begin
      case (rx_byte_q)
        8'hE0: begin
          if (state_q == S_IDLE) state_q <= S_EXT;
        end
        8'hF0: begin
          if (state_q == S_IDLE)     state_q <= S_REL;
          else if (state_q == S_EXT) state_q <= S_EXT_REL;
        end
        8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE: begin
        end
        default: begin
          state_q  <= S_IDLE;
          matrix_q <= dec_brk ? (matrix_q & ~dec_mask) : (matrix_q | dec_mask);
          case (dec_code)
            9'h014: mod_q[0] <= ~dec_brk;
            9'h114: mod_q[1] <= ~dec_brk;
            9'h011: mod_q[2] <= ~dec_brk;
            9'h111: mod_q[3] <= ~dec_brk;
            9'h005: f1_q     <= ~dec_brk;
            9'h078: f11_q    <= ~dec_brk;
            9'h007: begin
              if (dec_brk) begin
                warm_q <= 1'b0;
                cold_q <= 1'b0;
                test_q <= 1'b0;
              end else if (!(warm_q || cold_q || test_q)) begin
                // Reset flavour is latched once at the first F12 make
                if (|mod_q[1:0])      cold_q <= 1'b1;
                else if (|mod_q[3:2]) test_q <= 1'b1;
                else                  warm_q <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      endcase
    end
  end

  assign F1         = f1_q;
  assign F11        = f11_q;
  assign warm_reset = warm_q;
  assign cold_reset = cold_q;
  assign test_reset = test_q;

  // ------------------------------------------------------------------
  // Port #FE read: a low address bit selects its row
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < 5; gi++) begin : g_col
    logic [7:0] col_bits;
    for (genvar gr = 0; gr < 8; gr++) begin : g_row
      assign col_bits[gr] = matrix_q[gr*5 + gi] & ~addr_hi[gr];
    end
    assign key_data[gi] = ~|col_bits;
  end

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Scoreboard bench for ps2_zx_keyboard: PS/2 frames in, matrix reads and
// hotkey levels checked against a key-layout reference model.
module tb_ps2_zx_keyboard;

  localparam int TMO = 300;

  logic       clk_sys  = 1'b0;
  logic       nRESET   = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] addr_hi  = 8'hFF;
  logic [4:0] key_data;
  logic       F1, F11, warm_reset, cold_reset, test_reset;

  ps2_zx_keyboard #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk_sys    (clk_sys),
    .nRESET     (nRESET),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .addr_hi    (addr_hi),
    .key_data   (key_data),
    .F1         (F1),
    .F11        (F11),
    .warm_reset (warm_reset),
    .cold_reset (cold_reset),
    .test_reset (test_reset)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string      name;
    logic [7:0] addr;
    logic [4:0] kd;
    logic [4:0] hot;
  } exp_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } cand_t;

  exp_t  sb[$];
  cand_t cands[$];
  int    checks   = 0;
  int    failures = 0;
  logic  probe    = 1'b0;

  // Reference model: key positions by name of the Spectrum layout
  int layout[8][5] = '{
    '{'h12, 'h1A, 'h22, 'h21, 'h2A},   // CS Z X C V
    '{'h1C, 'h1B, 'h23, 'h2B, 'h34},   // A S D F G
    '{'h15, 'h1D, 'h24, 'h2D, 'h2C},   // Q W E R T
    '{'h16, 'h1E, 'h26, 'h25, 'h2E},   // 1 2 3 4 5
    '{'h45, 'h46, 'h3E, 'h3D, 'h36},   // 0 9 8 7 6
    '{'h4D, 'h44, 'h43, 'h3C, 'h35},   // P O I U Y
    '{'h5A, 'h4B, 'h42, 'h3B, 'h33},   // ENTER L K J H
    '{'h29, 'h59, 'h3A, 'h31, 'h32}    // SPACE SS M N B
  };
  bit mat[8][5];
  bit lctrl, rctrl, lalt, ralt, m_f1, m_f11;
  int m_f12;  // 0 none, 1 warm, 2 cold, 3 test

  function automatic void model_reset();
    foreach (mat[r, c]) mat[r][c] = 1'b0;
    lctrl = 0; rctrl = 0; lalt = 0; ralt = 0;
    m_f1 = 0; m_f11 = 0; m_f12 = 0;
  endfunction

  function automatic void model_apply(bit ext, logic [7:0] code, bit brk);
    int pr[$];
    int pc[$];
    if (!ext) begin
      foreach (layout[r, c]) if (layout[r][c] == int'(code)) begin pr.push_back(r); pc.push_back(c); end
      case (code)
        8'h14: begin pr.push_back(7); pc.push_back(1); lctrl = !brk; end
        8'h11: lalt = !brk;
        8'h66: begin pr.push_back(0); pc.push_back(0); pr.push_back(4); pc.push_back(0); end
        8'h05: m_f1 = !brk;
        8'h78: m_f11 = !brk;
        8'h07: begin
          if (brk) m_f12 = 0;
          else if (m_f12 == 0) m_f12 = (lctrl || rctrl) ? 2 : ((lalt || ralt) ? 3 : 1);
        end
        default: ;
      endcase
    end else begin
      case (code)
        8'h5A: begin pr.push_back(6); pc.push_back(0); end
        8'h14: begin pr.push_back(7); pc.push_back(1); rctrl = !brk; end
        8'h11: ralt = !brk;
        8'h6B: begin pr.push_back(0); pc.push_back(0); pr.push_back(3); pc.push_back(4); end
        8'h72: begin pr.push_back(0); pc.push_back(0); pr.push_back(4); pc.push_back(4); end
        8'h75: begin pr.push_back(0); pc.push_back(0); pr.push_back(4); pc.push_back(3); end
        8'h74: begin pr.push_back(0); pc.push_back(0); pr.push_back(4); pc.push_back(2); end
        default: ;
      endcase
    end
    foreach (pr[i]) mat[pr[i]][pc[i]] = !brk;
  endfunction

  function automatic logic [4:0] model_kd(logic [7:0] a);
    logic [4:0] k;
    k = 5'h1F;
    foreach (mat[r, c]) if (!a[r] && mat[r][c]) k[c] = 1'b0;
    return k;
  endfunction

  function automatic logic [4:0] model_hot();
    return {m_f1, m_f11, m_f12 == 1, m_f12 == 2, m_f12 == 3};
  endfunction

  // Stimulus helpers
  task automatic tick(int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bits(logic [10:0] bits, int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(4);
      ps2_clk = 1'b0;
      tick(4);
      ps2_clk = 1'b1;
    end
    tick(4);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] b, bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bits({1'b1, par, b, 1'b0}, 11);
  endtask

  task automatic send_key(bit ext, logic [7:0] code, bit brk);
    if (ext) send_frame(8'hE0, 1'b0);
    if (brk) send_frame(8'hF0, 1'b0);
    send_frame(code, 1'b0);
    model_apply(ext, code, brk);
  endtask

  task automatic probe_chk(string name, logic [7:0] a);
    exp_t e;
    tick(2);
    e.name = name;
    e.addr = a;
    e.kd   = model_kd(a);
    e.hot  = model_hot();
    sb.push_back(e);
    addr_hi = a;
    probe   = 1'b1;
    tick(1);
    probe   = 1'b0;
  endtask

  // Monitor: pops one expectation per read strobe
  always @(negedge clk_sys) begin
    if (probe) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty: read with no expectation queued");
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (key_data !== e.kd) begin
          failures++;
          $display("FAIL %s key_data addr_hi=%02h: got %02h expected %02h", e.name, e.addr, key_data, e.kd);
        end
        checks++;
        if ({F1, F11, warm_reset, cold_reset, test_reset} !== e.hot) begin
          failures++;
          $display("FAIL %s hotkeys {F1,F11,warm,cold,test}: got %05b expected %05b", e.name,
                   {F1, F11, warm_reset, cold_reset, test_reset}, e.hot);
        end
        $display("read %s addr_hi=%02h key_data=%02h hot=%05b", e.name, e.addr, key_data,
                 {F1, F11, warm_reset, cold_reset, test_reset});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cand_t cd;
    logic [7:0] ign[4] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE};
    model_reset();
    foreach (layout[r, c]) begin cd.ext = 1'b0; cd.code = 8'(layout[r][c]); cands.push_back(cd); end
    foreach (ign[i]) begin end
    cd.ext = 1'b0; cd.code = 8'h14; cands.push_back(cd);
    cd.code = 8'h11; cands.push_back(cd);
    cd.code = 8'h66; cands.push_back(cd);
    cd.code = 8'h05; cands.push_back(cd);
    cd.code = 8'h78; cands.push_back(cd);
    cd.code = 8'h07; cands.push_back(cd);
    cd.ext = 1'b1; cd.code = 8'h5A; cands.push_back(cd);
    cd.code = 8'h6B; cands.push_back(cd);
    cd.code = 8'h72; cands.push_back(cd);
    cd.code = 8'h75; cands.push_back(cd);
    cd.code = 8'h74; cands.push_back(cd);

    // Reset values, checked while held in reset and after release
    tick(3);
    probe_chk("reset_held", 8'h00);
    nRESET = 1'b1;
    probe_chk("reset_fe", 8'hFE);
    probe_chk("reset_7f", 8'h7F);
    probe_chk("reset_00", 8'h00);

    // Single key make / break
    send_key(1'b0, 8'h1C, 1'b0);
    probe_chk("a_make", 8'hFD);
    probe_chk("a_make_ff", 8'hFF);
    send_key(1'b0, 8'h1C, 1'b1);
    probe_chk("a_break", 8'hFD);

    // Extended composite cursor key
    send_key(1'b1, 8'h6B, 1'b0);
    probe_chk("left_fe", 8'hFE);
    probe_chk("left_f7", 8'hF7);
    probe_chk("left_00", 8'h00);
    send_key(1'b1, 8'h6B, 1'b1);
    probe_chk("left_rel_fe", 8'hFE);
    probe_chk("left_rel_f7", 8'hF7);

    // Bad parity dropped; it also discards a pending E0
    send_frame(8'h1C, 1'b1);
    probe_chk("bad_parity", 8'hFD);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h6B, 1'b1);
    send_frame(8'h6B, 1'b0);
    model_apply(1'b0, 8'h6B, 1'b0);
    probe_chk("bad_parity_clears_ext", 8'h00);

    // Partial frame then timeout, then a clean frame
    send_bits(11'h000, 4);
    tick(TMO + 10);
    send_key(1'b0, 8'h1C, 1'b0);
    probe_chk("after_timeout", 8'hFD);
    send_key(1'b0, 8'h1C, 1'b1);

    // F12 hotkey flavours
    send_key(1'b0, 8'h14, 1'b0);
    send_key(1'b0, 8'h07, 1'b0);
    probe_chk("ctrl_f12", 8'h7F);
    send_key(1'b0, 8'h07, 1'b1);
    probe_chk("ctrl_f12_rel", 8'h7F);
    send_key(1'b0, 8'h14, 1'b1);
    send_key(1'b1, 8'h11, 1'b0);
    send_key(1'b0, 8'h07, 1'b0);
    probe_chk("alt_f12", 8'hFF);
    send_key(1'b0, 8'h07, 1'b1);
    send_key(1'b1, 8'h11, 1'b1);
    send_key(1'b0, 8'h07, 1'b0);
    probe_chk("plain_f12", 8'hFF);
    send_key(1'b0, 8'h07, 1'b1);
    send_key(1'b0, 8'h05, 1'b0);
    send_key(1'b0, 8'h78, 1'b0);
    probe_chk("f1_f11", 8'hFF);
    send_key(1'b0, 8'h05, 1'b1);
    send_key(1'b0, 8'h78, 1'b1);

    // Composite release clears CS even with Left Shift still held
    send_key(1'b0, 8'h12, 1'b0);
    send_key(1'b0, 8'h66, 1'b0);
    probe_chk("bksp_held_ef", 8'hEF);
    send_key(1'b0, 8'h66, 1'b1);
    probe_chk("bksp_rel_fe", 8'hFE);
    probe_chk("bksp_rel_ef", 8'hEF);
    send_key(1'b0, 8'h12, 1'b1);

    // Randomised key traffic with ignored bytes sprinkled in
    for (int n = 0; n < 120; n++) begin
      cand_t k;
      bit brk;
      logic [7:0] a;
      k = cands[$urandom_range(0, cands.size() - 1)];
      brk = bit'($urandom_range(0, 1));
      if (!k.ext && k.code == 8'h07 && !brk && m_f12 != 0) brk = 1'b1;
      if ($urandom_range(0, 7) == 0) send_frame(ign[$urandom_range(0, 3)], 1'b0);
      send_key(k.ext, k.code, brk);
      if ($urandom_range(0, 1) == 1) a = ~(8'd1 << $urandom_range(0, 7));
      else a = 8'($urandom_range(0, 255));
      probe_chk("random", a);
    end

    // Reset asserted mid-frame with keys and F1 held
    send_key(1'b0, 8'h1C, 1'b0);
    send_key(1'b0, 8'h05, 1'b0);
    probe_chk("pre_reset", 8'h00);
    send_bits(11'h000, 3);
    nRESET = 1'b0;
    model_reset();
    probe_chk("reset_mid_frame", 8'h00);
    nRESET = 1'b1;
    probe_chk("after_reset", 8'h00);

    tick(5);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: %0d expectations never read, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
